// File: rtl/sound_pkg.sv
// Shared constants and types for the sound mixer and its I2S output stage.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sound_pkg;

    localparam int SLOT_BITS    = 32;
    localparam int FRAME_BITS   = 64;
    localparam int BCLK_PER_FS  = 64;
    localparam int TICKS_PER_FS = 128;

    // Mixer -> i2s_out sample type
    typedef logic signed [15:0] sample16_t;

    // Accumulator step for a clock enable at TICKS_PER_FS * sample_rate
    function automatic logic [27:0] tick_increment(input int sample_rate);
        return 28'(TICKS_PER_FS * sample_rate);
    endfunction

endpackage

// File: rtl/frac_ce_gen.sv
// Fractional clock-enable generator: ce averages increment/clock_rate per clk.
// Latency: ce registered, one clk after the accumulator crosses clock_rate.
// Backpressure: none; stalls (no ce, state held) while clock_rate < 2*increment or is 0.
module frac_ce_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] clock_rate,
    input  logic [27:0] increment,
    output logic        ce
);

    logic [27:0] acc;
    logic [28:0] sum;
    logic [28:0] min_rate;
    logic        run;

    // Next accumulator value and the rate guard that keeps ce at or below clk/2
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, increment};
        min_rate = {increment, 1'b0};
        run      = (clock_rate != 28'd0) && ({1'b0, clock_rate} >= min_rate);
    end

    // Accumulate; on overflow past clock_rate wrap and emit a single-cycle ce
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            ce <= 1'b0;
            if (run) begin
                if (sum >= {1'b0, clock_rate}) begin
                    acc <= 28'(sum - {1'b0, clock_rate});
                    ce  <= 1'b1;
                end else begin
                    acc <= sum[27:0];
                end
            end
        end
    end

endmodule

// File: rtl/i2s_out.sv
// I2S serialiser: 64-bit stereo frame (two 32-bit slots) with BCLK from a fractional ce.
// Latency: pair latched at frame start, MSB out 1 BCLK later (0 with I2S_OUT_LEFT_JUSTIFIED_EN).
// Backpressure: none; inputs sampled only at frame start, all outputs frozen while no ticks.
module i2s_out
    import sound_pkg::*;
#(
    parameter int SAMPLE_RATE = 48000,
    parameter int SAMPLE_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [27:0]                clock_rate,
    input  logic signed [SAMPLE_W-1:0] sample_l,
    input  logic signed [SAMPLE_W-1:0] sample_r,
    output logic                       i2s_bclk,
    output logic                       i2s_lrck,
    output logic                       i2s_data,
    output logic                       sample_strobe
);

    localparam logic [27:0] INCR = tick_increment(SAMPLE_RATE);
    localparam logic [5:0]  SW   = 6'(SAMPLE_W);

    logic                       tick;
    logic                       fall;
    logic                       wrap;
    logic [5:0]                 bit_cnt;
    logic [5:0]                 next_cnt;
    logic [5:0]                 k6;
    logic [5:0]                 idx;
    logic                       in_slot;
    logic                       data_bit;
    logic [31:0]                w;
    logic signed [SAMPLE_W-1:0] hold_l;
    logic signed [SAMPLE_W-1:0] hold_r;

    frac_ce_gen u_tick (
        .clk        (clk),
        .reset      (reset),
        .clock_rate (clock_rate),
        .increment  (INCR),
        .ce         (tick)
    );

    // Next bit position and the serial bit it carries; at frame start the left
    // word comes straight from the input since it is being latched this clk
    always_comb begin
        next_cnt = bit_cnt + 6'd1;
        fall     = tick & i2s_bclk;
        wrap     = (next_cnt == 6'd0);
        k6       = {1'b0, next_cnt[4:0]};
        w        = '0;
        if (next_cnt[5]) begin
            w[SAMPLE_W-1:0] = hold_r;
        end else begin
            w[SAMPLE_W-1:0] = wrap ? sample_l : hold_l;
        end
`ifdef I2S_OUT_LEFT_JUSTIFIED_EN
        in_slot = (k6 < SW);
        idx     = SW - 6'd1 - k6;
`else
        in_slot = (k6 >= 6'd1) && (k6 <= SW);
        idx     = SW - k6;
`endif
        data_bit = in_slot ? w[idx[4:0]] : 1'b0;
    end

    // Toggle BCLK per tick; on falling ticks advance the bit, update lrck/data
    // and latch the next pair at the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            i2s_bclk      <= 1'b0;
            i2s_lrck      <= 1'b0;
            i2s_data      <= 1'b0;
            sample_strobe <= 1'b0;
            bit_cnt       <= 6'd63;
            hold_l        <= '0;
            hold_r        <= '0;
        end else begin
            sample_strobe <= 1'b0;
            if (tick) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (fall) begin
                bit_cnt  <= next_cnt;
                i2s_lrck <= next_cnt[5];
                i2s_data <= data_bit;
                if (wrap) begin
                    hold_l        <= sample_l;
                    hold_r        <= sample_r;
                    sample_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/i2s_out.md
Name: i2s_out

Overview:
- Downstream stage of the sound mixer. Consumes the 16-bit signed stereo mix (sample_l/sample_r) in the clk domain.
- Serialises the mix to an external I2S DAC as a 64-bit frame (two 32-bit slots), producing BCLK, LRCK and SDATA.
- Bit clock is derived from clk by a fractional phase accumulator driven by the same clock_rate value the mixer uses, so no PLL is needed.

Parameters:
- SAMPLE_RATE, 48000, output frame rate in Hz; BCLK = 64*SAMPLE_RATE.
- SAMPLE_W, 16, sample width; must be 1..32.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clock_rate  in  28  frequency of clk in Hz; sampled every cycle.
- sample_l  in  SAMPLE_W  left sample, two's complement.
- sample_r  in  SAMPLE_W  right sample, two's complement.
- i2s_bclk  out  1  bit clock, registered.
- i2s_lrck  out  1  word select; 0 = left slot, 1 = right slot; registered.
- i2s_data  out  1  serial data, MSB first; registered.
- sample_strobe  out  1  one-clk pulse when a new L/R pair is latched.

Behaviour:
- Tick generator:
  - 28-bit accumulator; each clk, acc += 128*SAMPLE_RATE.
  - If acc >= clock_rate: acc -= clock_rate and tick = 1.
  - If clock_rate < 2*128*SAMPLE_RATE, or clock_rate == 0: no ticks are generated and all outputs hold their current values.
- Each tick toggles i2s_bclk. A 1→0 toggle is the "falling tick".
- Bit counter bit_cnt (6 bits) advances only on falling ticks, mod 64, wrapping 63→0.
- Output updates on a falling tick, all in the same clk as the bclk fall:
  - i2s_lrck = new bit_cnt[5].
  - Slot index k = new bit_cnt[4:0]; W = hold_l when bit_cnt[5] = 0, else hold_r.
  - I2S mode (default): i2s_data = W[SAMPLE_W-k] for 1 <= k <= SAMPLE_W, else 0. The MSB appears one BCLK after the LRCK edge.
- Latch:
  - On the falling tick where bit_cnt wraps to 0, capture sample_l into hold_l and sample_r into hold_r in the same clk.
  - sample_strobe = 1 for exactly that clk.
  - Inputs may change at any other time without affecting the frame in flight.
- Rising ticks change only i2s_bclk, so DAC sampling of data/lrck sees stable values.
- Reset values:
  - i2s_bclk = 0, i2s_lrck = 0, i2s_data = 0, sample_strobe = 0.
  - acc = 0, bit_cnt = 63, hold_l = hold_r = 0.
- Reset mid-frame: outputs drop to reset values on the next clk. The first falling tick after reset yields bit_cnt = 0 and a fresh latch.
- Tick frequency ≤ clk/2 is guaranteed by the clock_rate check, so at most one tick occurs per clk.
- Latency: a sample present on the latch clk appears at the DAC starting 1 BCLK later (I2S mode) and is fully shifted out within 1 frame.

Optional Feature:
- Macro I2S_OUT_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. i2s_data = W[SAMPLE_W-1-k] for 0 <= k <= SAMPLE_W-1, else 0, so the MSB coincides with the LRCK edge. Latch timing is unchanged.
- Undefined: standard I2S one-bit delay as described above.

Decomposition:
- Shared package sound_pkg holds:
  - SLOT_BITS = 32 and FRAME_BITS = 64.
  - BCLK_PER_FS = 64 and TICKS_PER_FS = 128.
  - Typedef sample16_t (signed 16-bit) for the mixer→i2s_out boundary.
- One sub-module: frac_ce_gen.
  - Inputs: clk, reset, clock_rate, increment.
  - Output: registered single-cycle ce.
  - It also replaces the duplicated 1 µs and SAA clock-enable accumulators in the mixer.

Test Plan:
- Tick rate: clock_rate = 50_000_000, SAMPLE_RATE = 48000, run 1 ms → exactly 48 sample_strobe pulses (±1) and 3072 BCLK rising edges (±1).
- I2S format: sample_l = 16'hA5C3, sample_r = 16'h8001, held for 2 frames → the second frame's left slot bits 1..16 = 1010010111000011, slot bits 0 and 17..31 = 0, lrck = 0. The right slot carries 1000000000000001 with lrck = 1.
- Latch isolation: change sample_l from 16'h1234 to 16'h7FFF when bit_cnt = 5 → the current frame still shifts 16'h1234; the next frame shifts 16'h7FFF.
- Rate guard: clock_rate = 12_000_000 (< 12_288_000) → i2s_bclk, i2s_lrck, i2s_data and sample_strobe stay constant for 10000 clk. Restoring 50_000_000 resumes ticking.
- Reset mid-frame: assert reset for 1 clk when bit_cnt = 40 → the next clk shows all outputs 0. After release, the first strobe coincides with the second tick, and that tick's frame starts with lrck = 0.
- With I2S_OUT_LEFT_JUSTIFIED_EN: sample_l = 16'hA5C3 → left slot bits 0..15 = 1010010111000011, the MSB is valid in the same clk as the lrck falling edge, and bits 16..31 = 0.
